vedic_mult_pipe: RTL

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready stream interface and a per-transaction signed/unsigned mode.
- Each operand is split into high and low halves.
- Four half-width quadrant products are formed with the existing Vedic multiplier cells.
- The quadrant products are combined with carry-lookahead adders over three registered stages.
- Sits in the datapath as a drop-in streaming multiply unit; accepts one operand pair per cycle at full throughput.

---
 rtl/vedic_mult_pipe.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe
//
// Pipelined Urdhva-Tiryagbhyam (Vedic) multiplier with a valid/ready stream
// interface, a per-transaction signed/unsigned mode and a sideband tag.
//
// Each operand is reduced to its magnitude and split into high and low
// halves. Four half-width quadrant products are formed by Vedic
// column-wise (vertical and crosswise) cells. The quadrant products are then
// combined by parallel-prefix carry-lookahead adders over three registered
// stages. The final sign is applied in the last stage.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block can accept a pair this cycle
//   in_a/in_b  multiplicand / multiplier (WIDTH bits)
//   in_signed  1 = two's-complement operands, 0 = unsigned
//   in_tag     sideband tag, returned unchanged with the product
//   out_valid  product valid
//   out_ready  downstream accepts the product
//   out_prod   product (2*WIDTH bits, two's complement when signed)
//   out_tag    tag belonging to out_prod
//   busy       any pipeline stage occupied
// ---------------------------------------------------------------------------
module vedic_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  // Vedic cell: the partial-product bits of every column k (all x[i]&y[j]
  // with i+j == k) are summed vertically/crosswise, and each column sum is
  // then accumulated at its weight.
  function automatic logic [WIDTH-1:0] vedicMul(input logic [H-1:0] x,
                                                input logic [H-1:0] y);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] col;
    logic [H-1:0]     xs;
    logic [H-1:0]     ys;
    acc = '0;
    for (int k = 0; k < 2*H-1; k++) begin
      col = '0;
      for (int i = 0; i < H; i++) begin
        if ((k >= i) && (k - i < H)) begin
          xs  = x >> i;
          ys  = y >> (k - i);
          col = col + {{(WIDTH-1){1'b0}}, xs[0] & ys[0]};
        end
      end
      acc = acc + (col << k);
    end
    return acc;
  endfunction

  // Kogge-Stone carry-lookahead adder: group generate/propagate are combined
  // over doubling spans, so every carry comes from a log-depth prefix tree.
  function automatic logic [PW-1:0] claAdd(input logic [PW-1:0] x,
                                           input logic [PW-1:0] y);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] gp;
    logic [PW-1:0] pp;
    g  = x & y;
    p  = x ^ y;
    gp = g;
    pp = p;
    for (int d = 1; d < PW; d = d * 2) begin
      gp = gp | (pp & (gp << d));
      pp = pp & (pp << d);
    end
    return p ^ (gp << 1);
  endfunction

  // Stage state
  logic               s1Valid_q, s2Valid_q, s3Valid_q;
  logic [WIDTH-1:0]   s1LL_q, s1HL_q, s1LH_q, s1HH_q;
  logic               s1Neg_q, s2Neg_q;
  logic [TAG_W-1:0]   s1Tag_q, s2Tag_q, s3Tag_q;
  logic [WIDTH:0]     s2Mid_q;
  logic [PW-H-1:0]    s2LowSum_q;
  logic [H-1:0]       s2LowBits_q;
  logic [PW-1:0]      s3Prod_q;

  // Next-state values
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH-1:0]   s1LL_d, s1HL_d, s1LH_d, s1HH_d;
  logic               s1Neg_d;
  logic [PW-1:0]      midSum, lowSumFull, upperFull, negFull;
  logic [WIDTH:0]     s2Mid_d;
  logic [PW-H-1:0]    s2LowSum_d;
  logic [PW-1:0]      mag;
  logic [PW-1:0]      s3Prod_d;
  logic               unusedBits;

  // Flow control
  logic s1Adv, s2Adv, s3Adv, inFire;

  // A stage may load when it is empty or its contents move on this edge,
  // so a full pipeline still accepts while it drains.
  always_comb begin
    s3Adv    = !s3Valid_q || out_ready;
    s2Adv    = !s2Valid_q || s3Adv;
    s1Adv    = !s1Valid_q || s2Adv;
    in_ready = rst_n && s1Adv;
    inFire   = in_valid && in_ready;
  end

  // Stage 1 datapath: magnitudes (so -2^(WIDTH-1) becomes 2^(WIDTH-1) as an
  // unsigned value) and the four quadrant products.
  always_comb begin
    aMag    = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    bMag    = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    s1LL_d  = vedicMul(aMag[H-1:0],     bMag[H-1:0]);
    s1HL_d  = vedicMul(aMag[WIDTH-1:H], bMag[H-1:0]);
    s1LH_d  = vedicMul(aMag[H-1:0],     bMag[WIDTH-1:H]);
    s1HH_d  = vedicMul(aMag[WIDTH-1:H], bMag[WIDTH-1:H]);
    s1Neg_d = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
  end

  // Stage 2/3 datapath. With a = aH*2^H + aL the magnitude product is
  // HH*2^WIDTH + mid*2^H + LL. Everything above bit H-1 is
  // upper = (LL >> H) + HH*2^H + mid, where the first two terms form
  // lowSum; the bottom H bits are LL's own low bits. The sign is applied
  // last as an invert-plus-one through the same adder.
  always_comb begin
    midSum     = claAdd(PW'(s1HL_q), PW'(s1LH_q));
    lowSumFull = claAdd(PW'(s1LL_q >> H), PW'({s1HH_q, {H{1'b0}}}));
    s2Mid_d    = midSum[WIDTH:0];
    s2LowSum_d = lowSumFull[PW-H-1:0];
    upperFull  = claAdd(PW'(s2LowSum_q), PW'(s2Mid_q));
    mag        = {upperFull[PW-H-1:0], s2LowBits_q};
    negFull    = claAdd(~mag, PW'(1));
    s3Prod_d   = s2Neg_q ? negFull : mag;
    // Adder bits above the widths that can ever be reached stay zero.
    unusedBits = ^{midSum[PW-1:WIDTH+1], lowSumFull[PW-1:PW-H],
                   upperFull[PW-1:PW-H]};
  end

  // Pipeline registers. A stage's valid bit follows its upstream whenever it
  // advances; data is only captured for a real transaction so the output
  // stays frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q   <= 1'b0;
      s2Valid_q   <= 1'b0;
      s3Valid_q   <= 1'b0;
      s1LL_q      <= '0;
      s1HL_q      <= '0;
      s1LH_q      <= '0;
      s1HH_q      <= '0;
      s1Neg_q     <= 1'b0;
      s1Tag_q     <= '0;
      s2Mid_q     <= '0;
      s2LowSum_q  <= '0;
      s2LowBits_q <= '0;
      s2Neg_q     <= 1'b0;
      s2Tag_q     <= '0;
      s3Prod_q    <= '0;
      s3Tag_q     <= '0;
    end else begin
      if (s1Adv) begin
        s1Valid_q <= inFire;
        if (inFire) begin
          s1LL_q  <= s1LL_d;
          s1HL_q  <= s1HL_d;
          s1LH_q  <= s1LH_d;
          s1HH_q  <= s1HH_d;
          s1Neg_q <= s1Neg_d;
          s1Tag_q <= in_tag;
        end
      end
      if (s2Adv) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Mid_q     <= s2Mid_d;
          s2LowSum_q  <= s2LowSum_d;
          s2LowBits_q <= s1LL_q[H-1:0];
          s2Neg_q     <= s1Neg_q;
          s2Tag_q     <= s1Tag_q;
        end
      end
      if (s3Adv) begin
        s3Valid_q <= s2Valid_q;
        if (s2Valid_q) begin
          s3Prod_q <= s3Prod_d;
          s3Tag_q  <= s2Tag_q;
        end
      end
    end
  end

  assign out_valid = s3Valid_q;
  assign out_prod  = s3Prod_q;
  assign out_tag   = s3Tag_q;
  assign busy      = s1Valid_q || s2Valid_q || s3Valid_q;

endmodule
